// File: rtl/reg_adder4.sv
// rtl/reg_adder4.sv - registered two-operand adder with carry or signed-overflow flag
module reg_adder4 #(
    parameter int WIDTH       = 4,
    parameter int SIGNED_MODE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Overflow
);

    logic [WIDTH:0] w_full;
    logic           w_carry;
    logic           w_sovf;
    logic           w_ovf;

    assign w_full  = {1'b0, A} + {1'b0, B};
    assign w_carry = w_full[WIDTH];
    // Signed overflow: like-signed operands yielding a result of the other sign.
    assign w_sovf  = (A[WIDTH-1] == B[WIDTH-1]) && (w_full[WIDTH-1] != A[WIDTH-1]);
    assign w_ovf   = (SIGNED_MODE != 0) ? w_sovf : w_carry;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Sum      <= '0;
            Overflow <= 1'b0;
        end else if (En) begin
            Sum      <= w_full[WIDTH-1:0];
            Overflow <= w_ovf;
        end
    end

endmodule

// File: tb/tb_reg_adder4.sv
// tb/tb_reg_adder4.sv - directed checks of reg_adder4 in unsigned and signed modes
module tb_reg_adder4;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] sum_u;
    logic       ovf_u;
    logic [3:0] sum_s;
    logic       ovf_s;

    int checks;
    int errors;

    reg_adder4 #(.WIDTH(4), .SIGNED_MODE(0)) dut_u (
        .Clk(Clk), .Reset(Reset), .En(En), .A(A), .B(B),
        .Sum(sum_u), .Overflow(ovf_u)
    );

    reg_adder4 #(.WIDTH(4), .SIGNED_MODE(1)) dut_s (
        .Clk(Clk), .Reset(Reset), .En(En), .A(A), .B(B),
        .Sum(sum_s), .Overflow(ovf_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed={ovf,sum}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [3:0] a, input logic [3:0] b);
        @(negedge Clk);
        En = en;
        A  = a;
        B  = b;
        @(posedge Clk);
        #1;
    endtask

    logic [4:0] exp_u;
    logic [4:0] exp_s;
    logic [4:0] full;
    int         t;

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        En     = 1'b0;
        A      = 4'd0;
        B      = 4'd0;
        #2;
        check("reset_u", {ovf_u, sum_u}, 5'b0_0000);
        check("reset_s", {ovf_s, sum_s}, 5'b0_0000);

        @(negedge Clk);
        Reset = 1'b0;
        step(1'b1, 4'd2, 4'd3);
        check("load5", {ovf_u, sum_u}, 5'b0_0101);

        // Asynchronous reset mid-cycle, then held through enabled edges.
        @(negedge Clk);
        #2;
        En = 1'b1; A = 4'd3; B = 4'd4;
        Reset = 1'b1;
        #1;
        check("async_reset", {ovf_u, sum_u}, 5'b0_0000);
        @(posedge Clk); #1;
        check("reset_hold1", {ovf_u, sum_u}, 5'b0_0000);
        @(posedge Clk); #1;
        check("reset_hold2", {ovf_s, sum_s}, 5'b0_0000);
        @(negedge Clk);
        Reset = 1'b0;

        step(1'b1, 4'd3, 4'd4);
        check("add_3_4", {ovf_u, sum_u}, 5'b0_0111);

        step(1'b1, 4'd9, 4'd8);
        check("add_9_8_u", {ovf_u, sum_u}, 5'b1_0001);
        check("add_9_8_s", {ovf_s, sum_s}, 5'b1_0001);

        step(1'b1, 4'd15, 4'd1);
        check("wrap_15_1_u", {ovf_u, sum_u}, 5'b1_0000);

        step(1'b1, 4'd2, 4'd2);
        check("load4", {ovf_u, sum_u}, 5'b0_0100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd6, 4'd7);
            check("hold_en0", {ovf_u, sum_u}, 5'b0_0100);
        end
        step(1'b1, 4'd6, 4'd7);
        check("en_6_7_u", {ovf_u, sum_u}, 5'b0_1101);
        check("en_6_7_s", {ovf_s, sum_s}, 5'b1_1101);

        step(1'b1, 4'd7, 4'd1);
        check("s_7_1", {ovf_s, sum_s}, 5'b1_1000);
        check("u_7_1", {ovf_u, sum_u}, 5'b0_1000);
        step(1'b1, 4'd8, 4'd8);
        check("s_8_8", {ovf_s, sum_s}, 5'b1_0000);
        check("u_8_8", {ovf_u, sum_u}, 5'b1_0000);
        step(1'b1, 4'd15, 4'd1);
        check("s_15_1", {ovf_s, sum_s}, 5'b0_0000);
        check("u_15_1", {ovf_u, sum_u}, 5'b1_0000);

        // Sweep: B steps every 25 ns, A every 50 ns, En toggles every cycle.
        exp_u = {ovf_u, sum_u};
        exp_s = {ovf_s, sum_s};
        exp_u = 5'b1_0000;
        exp_s = 5'b0_0000;
        for (int k = 0; k < 80; k++) begin
            t = k * 10;
            step(k[0], 4'((t / 50) % 16), 4'((t / 25) % 16));
            if (En) begin
                full  = {1'b0, A} + {1'b0, B};
                exp_u = full;
                exp_s = {(A[3] == B[3]) && (full[3] != A[3]), full[3:0]};
            end
            check("sweep_u", {ovf_u, sum_u}, exp_u);
            check("sweep_s", {ovf_s, sum_s}, exp_s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
